// File: rtl/asend_rr_arbiter.sv
// Round-robin arbiter sharing one asend/aready handshake channel.
// Grants one requester at a time and pulses done when the channel returns to READY.
module asend_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int CW   = 16
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              asend,
    output logic [DW-1:0]     adata,
    input  logic              aready,
    output logic [CW-1:0]     xfer_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND       = 2'd1,
        WAIT_BUSY  = 2'd2,
        WAIT_READY = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              asend_q, asend_d;
    logic [DW-1:0]     adata_q, adata_d;
    logic [PW-1:0]     win_q, win_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              arb_valid;
    logic [PW-1:0]     arb_idx;
    logic [PW:0]       sum;

    // Search upward from ptr+1, wrapping; ptr+k never exceeds 2*NREQ-1.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        sum       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            if (!arb_valid && req[sum[PW-1:0]]) begin
                arb_valid = 1'b1;
                arb_idx   = sum[PW-1:0];
            end
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (aready && arb_valid) state_d = SEND;
            SEND:       state_d = WAIT_BUSY;
            WAIT_BUSY:  if (!aready) state_d = WAIT_READY;
            WAIT_READY: if (aready) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d   = gnt_q;
        done_d  = '0;
        asend_d = (state_d == SEND);
        adata_d = adata_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (1'b1)
            (state_q == IDLE) && (state_d == SEND): begin
                gnt_d   = NREQ'(1) << arb_idx;
                adata_d = req_data[int'(arb_idx)*DW +: DW];
                win_d   = arb_idx;
            end
            (state_q == WAIT_READY) && (state_d == IDLE): begin
                done_d = gnt_q;
                gnt_d  = '0;
                ptr_d  = win_q;
                cnt_d  = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            gnt_q   <= '0;
            done_q  <= '0;
            asend_q <= 1'b0;
            adata_q <= '0;
            win_q   <= '0;
            ptr_q   <= PW'(NREQ-1);
            cnt_q   <= '0;
        end else begin
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            asend_q <= asend_d;
            adata_q <= adata_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign asend    = asend_q;
    assign adata    = adata_q;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_asend_rr_arbiter.sv
// Bench for asend_rr_arbiter: directed scenarios plus random traffic
// checked against a round-robin reference model.
module tb_asend_rr_arbiter;

    logic        aclk = 1'b0;
    logic        arst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        asend;
    logic [7:0]  adata;
    logic        aready;
    logic [3:0]  xfer_cnt;

    int tests = 0;
    int fails = 0;
    int ptr_m = 3;
    int cnt_m = 0;

    asend_rr_arbiter #(.NREQ(4), .DW(8), .CW(4)) dut (
        .aclk     (aclk),
        .arst     (arst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .asend    (asend),
        .adata    (adata),
        .aready   (aready),
        .xfer_cnt (xfer_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic do_reset();
        arst = 1'b1;
        req  = 4'b0000;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_asend", asend, 0);
        chk("rst_adata", adata, 0);
        chk("rst_cnt", xfer_cnt, 0);
        @(negedge aclk);
        arst   = 1'b0;
        aready = 1'b1;
        ptr_m  = 3;
        cnt_m  = 0;
    endtask

    task automatic xfer(input logic [3:0] r, input logic [31:0] d,
                        input int pre, input int busy, input bit drop);
        int w;
        logic [7:0] ed;
        logic [3:0] eg;
        req      = r;
        req_data = d;
        aready   = 1'b1;
        w  = pick(r, ptr_m);
        eg = 4'b0001 << w;
        ed = d[w*8 +: 8];
        @(posedge aclk); @(negedge aclk);
        chk("grant", gnt, eg);
        chk("asend_hi", asend, 1);
        chk("adata", adata, ed);
        chk("done_lo", done, 0);
        if (drop) req[w] = 1'b0;
        req_data = req_data + 32'h1111_1111;
        for (int c = 0; c < 1 + pre + busy; c++) begin
            aready = (c < 1 + pre);
            @(posedge aclk); @(negedge aclk);
            chk("gnt_hold", gnt, eg);
            chk("asend_lo", asend, 0);
            chk("adata_hold", adata, ed);
            chk("done_wait", done, 0);
            chk("cnt_hold", xfer_cnt, cnt_m);
        end
        aready = 1'b1;
        @(posedge aclk); @(negedge aclk);
        ptr_m = w;
        cnt_m = (cnt_m + 1) % 16;
        chk("done_pulse", done, eg);
        chk("gnt_drop", gnt, 0);
        chk("asend_done", asend, 0);
        chk("cnt", xfer_cnt, cnt_m);
    endtask

    initial begin
        arst     = 1'b1;
        req      = 4'b0000;
        req_data = '0;
        aready   = 1'b1;

        // single requester
        do_reset();
        xfer(4'b0001, 32'h0000_00A5, 0, 3, 1'b0);

        // all requesting, grant order 0,1,2,3,0,1,2,3
        do_reset();
        for (int i = 0; i < 8; i++) begin
            xfer(4'b1111, $urandom, 0, 1, 1'b0);
            chk("rr_order", ptr_m, i % 4);
        end
        chk("cnt8", xfer_cnt, 8);

        // busy channel holds off the grant
        req    = 4'b0100;
        aready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk); @(negedge aclk);
            chk("busy_gnt", gnt, 0);
            chk("busy_asend", asend, 0);
        end
        xfer(4'b0100, $urandom, 0, 2, 1'b0);

        // payload stability while granted
        xfer(4'b0010, 32'h0000_1100, 1, 2, 1'b1);

        // random traffic with idle gaps
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 4'b0000;
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                    aready = 1'($urandom_range(0, 1));
                    @(posedge aclk); @(negedge aclk);
                    chk("idle_gnt", gnt, 0);
                    chk("idle_asend", asend, 0);
                    chk("idle_done", done, 0);
                end
            end
            xfer(4'($urandom_range(1, 15)), $urandom,
                 int'($urandom_range(0, 2)), int'($urandom_range(1, 4)),
                 1'($urandom_range(0, 1)));
        end

        // reset in WAIT_READY aborts the transfer
        req    = 4'b0010;
        aready = 1'b1;
        @(posedge aclk); @(negedge aclk);
        chk("mid_gnt", gnt, 4'b0001 << pick(4'b0010, ptr_m));
        @(posedge aclk); @(negedge aclk);
        aready = 1'b0;
        @(posedge aclk); @(negedge aclk);
        chk("mid_hold", gnt, 4'b0010);
        do_reset();
        xfer(4'b1000, $urandom, 0, 1, 1'b0);

        // counter wrap with a 4-bit counter
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            xfer(4'($urandom_range(1, 15)), $urandom, 0, 1, 1'b0);
            if (i == 15) chk("wrap15", xfer_cnt, 15);
            if (i == 16) chk("wrap16", xfer_cnt, 0);
            if (i == 17) chk("wrap17", xfer_cnt, 1);
        end
        req = 4'b0000;
        @(posedge aclk); @(negedge aclk);
        chk("end_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/asend_rr_arbiter.md
Name: asend_rr_arbiter

Overview:
- Round-robin arbiter that shares one asend/aready handshake channel among NREQ requesters.
- Sits in the aclk domain in front of the send-side handshake FSM. Drives asend plus a registered payload, and watches aready for the BUSY phase and the return to READY.
- Returns a one-hot grant and a one-cycle done pulse to the winning requester.
- Keeps a running count of completed transfers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, payload width per requester.
- CW, 16, width of the completed-transfer counter.

Ports:
- aclk  in  1  clock, rising edge.
- arst  in  1  reset, asynchronous assert, active-high.
- req  in  NREQ  request level per requester; held until that requester's done.
- req_data  in  NREQ*DW  payloads; requester i occupies bits [i*DW +: DW].
- gnt  out  NREQ  one-hot grant, held for the whole transfer.
- done  out  NREQ  one-cycle pulse to the granted requester when its transfer completes.
- asend  out  1  send strobe to the handshake FSM.
- adata  out  DW  payload registered at grant, stable while busy.
- aready  in  1  from the handshake FSM: 1 = READY, 0 = BUSY.
- xfer_cnt  out  CW  completed transfers, wraps modulo 2^CW.

Behaviour:
- Reset (arst=1, asynchronous):
  - State is IDLE; gnt=0, done=0, asend=0, adata=0, xfer_cnt=0.
  - Round-robin pointer = NREQ-1, so requester 0 has top priority first.
- FSM states: IDLE, SEND, WAIT_BUSY, WAIT_READY.
- IDLE:
  - Proceeds only if aready=1 and |req=1.
  - Winner = first set req bit searching upward from (ptr+1) mod NREQ, wrapping.
  - At that edge: gnt <= onehot(winner), adata <= req_data[winner], go to SEND.
  - If aready=0, stay in IDLE whatever req is.
- SEND:
  - asend=1 for exactly this one cycle (registered output, high only in SEND).
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - asend=0. Stay while aready=1.
  - When aready=0, go to WAIT_READY.
- WAIT_READY:
  - Stay while aready=0.
  - When aready=1:
    - done[winner] pulses for 1 cycle, together with gnt dropping to 0.
    - ptr <= winner; xfer_cnt <= xfer_cnt+1.
    - Go to IDLE.
- Latency: with the handshake FSM answering immediately, the minimum gap between grant edges is 4 cycles (IDLE, SEND, WAIT_BUSY, WAIT_READY). A 0-cycle aack gives aready low for 1 cycle.
- Fairness: a requester that holds req continuously waits at most NREQ-1 other transfers.
- Request changes:
  - req deasserting after grant does not abort the transfer.
  - req/req_data changes after the grant edge do not affect adata.
- Simultaneous events:
  - New requests arriving in the done cycle are arbitrated in the next IDLE cycle, using the updated ptr.
  - A requester re-requesting right after done competes normally and loses to any other pending requester.
- xfer_cnt wraps from 2^CW-1 to 0 with no flag.
- arst mid-transfer returns everything to reset values immediately. No done is issued for the aborted transfer. Resetting the handshake FSM in step is the integrator's job.
- gnt always has at most one bit set (onehot0). done is only ever set on the bit granted in the previous cycle.

Test Plan:
- Single requester: req=4'b0001, req_data[7:0]=8'hA5, aready low 3 cycles after asend -> gnt=0001; asend high exactly 1 cycle; adata=A5; done[0] pulses when aready returns; xfer_cnt=1.
- All requesting: req=4'b1111 held, 8 transfers -> grant order 0,1,2,3,0,1,2,3; xfer_cnt=8.
- Busy channel: aready=0 at start with req=4'b0100 -> no gnt and no asend until aready=1, then gnt=0100.
- Data stability: req_data[1] changes from 8'h11 to 8'h22 while gnt=0010 -> adata stays 11 through done.
- Reset mid-transfer: arst pulsed in WAIT_READY -> gnt=0, asend=0, done=0, xfer_cnt=0; after release with req=4'b1000, requester 0's absence means requester 3 is granted.
- Wrap: CW=4, 17 transfers -> xfer_cnt reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
